seq_shift_unit: RTL and testbench

//   Multi-cycle, parametrised shift/rotate unit for the ALU datapath.

---
 rtl/seq_shift_unit.sv | 163 ++++++++++++++++
 tb/tb_seq_shift_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle shift/rotate unit, SHIFT_STEP bits per clock, start/busy/done handshake.
// Revision: 1.0
`default_nettype none

module seq_shift_unit #(
  parameter int Operand_SIZE = 16,
  parameter int ALU_OUT      = 32,
  parameter int SHAMT_WIDTH  = 5,
  parameter int SHIFT_STEP   = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [Operand_SIZE-1:0] A,
  input  logic [Operand_SIZE-1:0] B,
  input  logic [2:0]              ALU_FUN,
  input  logic                    SHIFT_Enable,
  output logic [ALU_OUT-1:0]      SHIFT_OUT,
  output logic                    SHIFT_Carry,
  output logic                    SHIFT_Busy,
  output logic                    SHIFT_Flag
);

  localparam int W    = Operand_SIZE;
  localparam int CNTW = $clog2(W + 1);
  localparam int IDXW = $clog2(W);
  localparam int NW   = ((SHAMT_WIDTH > CNTW) ? SHAMT_WIDTH : CNTW) + 1;

  localparam logic [CNTW-1:0] W_C    = CNTW'(W);
  localparam logic [CNTW-1:0] STEP_C = CNTW'(SHIFT_STEP);
  localparam logic [CNTW-1:0] ONE_C  = CNTW'(1);
  localparam logic [NW-1:0]   W_N    = NW'(W);

  localparam logic [2:0] FN_LSR = 3'b000;
  localparam logic [2:0] FN_LSL = 3'b001;
  localparam logic [2:0] FN_ASR = 3'b010;
  localparam logic [2:0] FN_ROR = 3'b011;
  localparam logic [2:0] FN_ROL = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    work;
  logic [2:0]      fun;
  logic [CNTW-1:0] remaining;

  logic [NW-1:0]   n_ext;
  logic [CNTW-1:0] n_eff;
  logic [CNTW-1:0] k;
  logic [IDXW-1:0] idx_lo, idx_hi;
  logic            last_step;
  logic [W-1:0]    shifted;
  logic            bit_out;
  logic            unused_b;

  // Only the low SHAMT_WIDTH bits of B carry the amount.
  assign unused_b = ^B;

  function automatic logic [ALU_OUT-1:0] extend(input logic [W-1:0] v, input logic [2:0] f);
    logic [ALU_OUT-1:0] r;
    if (f == FN_ASR) r = ALU_OUT'($signed(v));
    else             r = ALU_OUT'(v);
    return r;
  endfunction

  // Effective amount: linear shifts saturate at W, rotates wrap modulo W.
  always_comb begin
    n_ext = NW'(B[SHAMT_WIDTH-1:0]);
    n_eff = '0;
    case (ALU_FUN)
      FN_LSR, FN_LSL, FN_ASR: n_eff = (n_ext > W_N) ? W_C : n_ext[CNTW-1:0];
      FN_ROR, FN_ROL:         n_eff = CNTW'(n_ext[IDXW-1:0]);
      default:                n_eff = '0;
    endcase
  end

  always_comb begin
    k         = (remaining < STEP_C) ? remaining : STEP_C;
    last_step = (remaining <= STEP_C);
    idx_lo    = IDXW'(k - ONE_C);
    idx_hi    = IDXW'(W_C - k);
    shifted   = work;
    bit_out   = 1'b0;
    case (fun)
      FN_LSR: begin shifted = work >> k;                        bit_out = work[idx_lo]; end
      FN_LSL: begin shifted = work << k;                        bit_out = work[idx_hi]; end
      FN_ASR: begin shifted = W'($signed(work) >>> k);          bit_out = work[idx_lo]; end
      FN_ROR: begin shifted = (work >> k) | (work << (W_C - k)); bit_out = work[idx_lo]; end
      FN_ROL: begin shifted = (work << k) | (work >> (W_C - k)); bit_out = work[idx_hi]; end
      default: begin shifted = work; bit_out = 1'b0; end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    SHIFT_Busy = 1'b0;
    SHIFT_Flag = 1'b0;
    case (state)
      S_IDLE:  if (SHIFT_Enable) state_nxt = S_LOAD;
      S_LOAD: begin
        SHIFT_Busy = 1'b1;
        state_nxt  = (remaining == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        SHIFT_Busy = 1'b1;
        if (last_step) state_nxt = S_DONE;
      end
      S_DONE: begin
        SHIFT_Flag = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Results are committed on the edge entering DONE so they are valid during DONE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      work        <= '0;
      fun         <= '0;
      remaining   <= '0;
      SHIFT_OUT   <= '0;
      SHIFT_Carry <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (SHIFT_Enable) begin
            work      <= A;
            fun       <= ALU_FUN;
            remaining <= n_eff;
          end
        end
        S_LOAD: begin
          if (remaining == '0) begin
            SHIFT_OUT   <= extend(work, fun);
            SHIFT_Carry <= 1'b0;
          end
        end
        S_SHIFT: begin
          work      <= shifted;
          remaining <= remaining - k;
          if (last_step) begin
            SHIFT_OUT   <= extend(shifted, fun);
            SHIFT_Carry <= bit_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: directed self-checking bench for seq_shift_unit (step 1 and step 4 instances).
// Revision: 1.0
`default_nettype none

module tb_seq_shift_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [2:0]  ALU_FUN = '0;
  logic        SHIFT_Enable = 1'b0;
  logic [31:0] SHIFT_OUT, out4;
  logic        SHIFT_Carry, SHIFT_Busy, SHIFT_Flag;
  logic        carry4, busy4, flag4;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  seq_shift_unit #(.Operand_SIZE(16), .ALU_OUT(32), .SHAMT_WIDTH(5), .SHIFT_STEP(1)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN), .SHIFT_Enable(SHIFT_Enable),
    .SHIFT_OUT(SHIFT_OUT), .SHIFT_Carry(SHIFT_Carry), .SHIFT_Busy(SHIFT_Busy), .SHIFT_Flag(SHIFT_Flag)
  );

  seq_shift_unit #(.Operand_SIZE(16), .ALU_OUT(32), .SHAMT_WIDTH(5), .SHIFT_STEP(4)) dut4 (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN), .SHIFT_Enable(SHIFT_Enable),
    .SHIFT_OUT(out4), .SHIFT_Carry(carry4), .SHIFT_Busy(busy4), .SHIFT_Flag(flag4)
  );

  // One start pulse, then scramble the inputs and record the flag cycle of both instances.
  task automatic run_op(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                        output int fc, output int fc4, output int busy_n);
    @(negedge CLK);
    ALU_FUN = f; A = a; B = b; SHIFT_Enable = 1'b1;
    @(negedge CLK);
    SHIFT_Enable = 1'b0; A = ~a; B = 16'hFFFF; ALU_FUN = 3'b111;
    fc = 0; fc4 = 0; busy_n = 0;
    for (int c = 1; c <= 60; c++) begin
      if (SHIFT_Busy) busy_n++;
      if (SHIFT_Flag && fc == 0) fc = c;
      if (flag4 && fc4 == 0) fc4 = c;
      if (fc != 0 && fc4 != 0) break;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    total++; if (SHIFT_OUT !== 32'h0) begin bad++; $display("FAIL reset_out: got %h want %h", SHIFT_OUT, 32'h0); end
    total++; if (SHIFT_Carry !== 1'b0) begin bad++; $display("FAIL reset_carry: got %b want 0", SHIFT_Carry); end
    total++; if (SHIFT_Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", SHIFT_Busy); end
    total++; if (SHIFT_Flag !== 1'b0) begin bad++; $display("FAIL reset_flag: got %b want 0", SHIFT_Flag); end
    RST = 1'b1;
  endtask

  task automatic test_lsl();
    int fc, fc4, bn;
    run_op(3'b001, 16'h8001, 16'd1, fc, fc4, bn);
    total++; if (SHIFT_OUT !== 32'h0000_0002) begin bad++; $display("FAIL lsl_out: got %h want %h", SHIFT_OUT, 32'h2); end
    total++; if (SHIFT_Carry !== 1'b1) begin bad++; $display("FAIL lsl_carry: got %b want 1", SHIFT_Carry); end
    total++; if (fc !== 3) begin bad++; $display("FAIL lsl_latency: got %0d want 3", fc); end
    total++; if (bn !== 2) begin bad++; $display("FAIL lsl_busy: got %0d want 2", bn); end
    @(negedge CLK);
    total++; if (SHIFT_Flag !== 1'b0) begin bad++; $display("FAIL lsl_flag_pulse: got %b want 0", SHIFT_Flag); end
    total++; if (SHIFT_OUT !== 32'h0000_0002) begin bad++; $display("FAIL lsl_hold: got %h want %h", SHIFT_OUT, 32'h2); end
  endtask

  task automatic test_asr();
    int fc, fc4, bn;
    run_op(3'b010, 16'h8000, 16'd4, fc, fc4, bn);
    total++; if (SHIFT_OUT !== 32'hFFFF_F800) begin bad++; $display("FAIL asr_out: got %h want %h", SHIFT_OUT, 32'hFFFF_F800); end
    total++; if (SHIFT_Carry !== 1'b0) begin bad++; $display("FAIL asr_carry: got %b want 0", SHIFT_Carry); end
    total++; if (bn !== 5) begin bad++; $display("FAIL asr_busy: got %0d want 5", bn); end
    total++; if (fc !== 6) begin bad++; $display("FAIL asr_latency: got %0d want 6", fc); end
    total++; if (out4 !== 32'hFFFF_F800) begin bad++; $display("FAIL asr_step4_out: got %h want %h", out4, 32'hFFFF_F800); end
  endtask

  task automatic test_rotate();
    int fc, fc4, bn;
    run_op(3'b011, 16'h0001, 16'd17, fc, fc4, bn);
    total++; if (SHIFT_OUT !== 32'h0000_8000) begin bad++; $display("FAIL ror_out: got %h want %h", SHIFT_OUT, 32'h8000); end
    total++; if (SHIFT_Carry !== 1'b1) begin bad++; $display("FAIL ror_carry: got %b want 1", SHIFT_Carry); end
    total++; if (fc !== 3) begin bad++; $display("FAIL ror_latency: got %0d want 3", fc); end
    run_op(3'b100, 16'h8000, 16'd16, fc, fc4, bn);
    total++; if (SHIFT_OUT !== 32'h0000_8000) begin bad++; $display("FAIL rol_out: got %h want %h", SHIFT_OUT, 32'h8000); end
    total++; if (SHIFT_Carry !== 1'b0) begin bad++; $display("FAIL rol_carry: got %b want 0", SHIFT_Carry); end
    total++; if (fc !== 2) begin bad++; $display("FAIL rol_latency: got %0d want 2", fc); end
  endtask

  task automatic test_pass();
    int fc, fc4, bn;
    run_op(3'b101, 16'hB234, 16'd3, fc, fc4, bn);
    total++; if (SHIFT_OUT !== 32'h0000_B234) begin bad++; $display("FAIL pass_out: got %h want %h", SHIFT_OUT, 32'hB234); end
    total++; if (SHIFT_Carry !== 1'b0) begin bad++; $display("FAIL pass_carry: got %b want 0", SHIFT_Carry); end
    total++; if (fc !== 2) begin bad++; $display("FAIL pass_latency: got %0d want 2", fc); end
  endtask

  task automatic test_lsr_saturate();
    int fc, fc4, bn;
    run_op(3'b000, 16'hFFFF, 16'd20, fc, fc4, bn);
    total++; if (SHIFT_OUT !== 32'h0) begin bad++; $display("FAIL lsr_out: got %h want %h", SHIFT_OUT, 32'h0); end
    total++; if (SHIFT_Carry !== 1'b1) begin bad++; $display("FAIL lsr_carry: got %b want 1", SHIFT_Carry); end
    total++; if (fc !== 18) begin bad++; $display("FAIL lsr_latency: got %0d want 18", fc); end
    total++; if (fc4 !== 6) begin bad++; $display("FAIL lsr_step4_latency: got %0d want 6", fc4); end
    total++; if (out4 !== 32'h0) begin bad++; $display("FAIL lsr_step4_out: got %h want %h", out4, 32'h0); end
    total++; if (carry4 !== 1'b1) begin bad++; $display("FAIL lsr_step4_carry: got %b want 1", carry4); end
  endtask

  task automatic test_back_to_back();
    int flags, busy_n;
    flags = 0; busy_n = 0;
    @(negedge CLK);
    ALU_FUN = 3'b001; A = 16'h0003; B = 16'd2; SHIFT_Enable = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge CLK);
      if (SHIFT_Flag) flags++;
      if (SHIFT_Busy) busy_n++;
    end
    SHIFT_Enable = 1'b0;
    total++; if (flags !== 3) begin bad++; $display("FAIL b2b_flags: got %0d want 3", flags); end
    total++; if (busy_n !== 9) begin bad++; $display("FAIL b2b_busy: got %0d want 9", busy_n); end
    total++; if (SHIFT_OUT !== 32'h0000_000C) begin bad++; $display("FAIL b2b_out: got %h want %h", SHIFT_OUT, 32'hC); end
    total++; if (SHIFT_Carry !== 1'b0) begin bad++; $display("FAIL b2b_carry: got %b want 0", SHIFT_Carry); end
    repeat (6) @(negedge CLK);
  endtask

  task automatic test_reset_midop();
    int fc, fc4, bn;
    @(negedge CLK);
    ALU_FUN = 3'b001; A = 16'h00FF; B = 16'd8; SHIFT_Enable = 1'b1;
    @(negedge CLK);
    SHIFT_Enable = 1'b0;
    repeat (2) @(negedge CLK);
    total++; if (SHIFT_Busy !== 1'b1) begin bad++; $display("FAIL midop_busy_before: got %b want 1", SHIFT_Busy); end
    #2 RST = 1'b0;
    #1;
    total++; if (SHIFT_OUT !== 32'h0) begin bad++; $display("FAIL midop_out: got %h want %h", SHIFT_OUT, 32'h0); end
    total++; if (SHIFT_Carry !== 1'b0) begin bad++; $display("FAIL midop_carry: got %b want 0", SHIFT_Carry); end
    total++; if (SHIFT_Busy !== 1'b0) begin bad++; $display("FAIL midop_busy: got %b want 0", SHIFT_Busy); end
    total++; if (SHIFT_Flag !== 1'b0) begin bad++; $display("FAIL midop_flag: got %b want 0", SHIFT_Flag); end
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL midop_step4_busy: got %b want 0", busy4); end
    @(negedge CLK);
    RST = 1'b1;
    run_op(3'b000, 16'h0010, 16'd4, fc, fc4, bn);
    total++; if (SHIFT_OUT !== 32'h0000_0001) begin bad++; $display("FAIL post_reset_out: got %h want %h", SHIFT_OUT, 32'h1); end
    total++; if (SHIFT_Carry !== 1'b0) begin bad++; $display("FAIL post_reset_carry: got %b want 0", SHIFT_Carry); end
    total++; if (fc !== 6) begin bad++; $display("FAIL post_reset_latency: got %0d want 6", fc); end
  endtask

  initial begin
    test_reset();
    test_lsl();
    test_asr();
    test_rotate();
    test_pass();
    test_lsr_saturate();
    test_back_to_back();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
